// File: rtl/gcd_engine_param.sv
// Parametrised GCD engine: one-cycle operand load, run-time choice of subtractive
// Euclid or binary Stein, result held on a valid/ready output until accepted.
module gcd_engine_param #(
   parameter int WIDTH  = 16,
   parameter int ITER_W = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a_in,
   input  logic [WIDTH-1:0]  b_in,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  gcd_out,
   output logic [ITER_W-1:0] iter_out,
   output logic              zero_flag
);

   localparam int K_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic               mode_q, mode_d;
   logic [WIDTH-1:0]   gcd_q, gcd_d;
   logic [ITER_W-1:0]  iter_out_q, iter_out_d;
   logic               zero_q, zero_d;

   logic [ITER_W-1:0]  iter_inc;
   logic [WIDTH-1:0]   diff_ab;
   logic [WIDTH-1:0]   diff_ba;

   // Saturating counter so very long subtractive runs never wrap to a small count.
   assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
   assign diff_ab  = a_q - b_q;
   assign diff_ba  = b_q - a_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      k_d        = k_q;
      iter_d     = iter_q;
      mode_d     = mode_q;
      gcd_d      = gcd_q;
      iter_out_d = iter_out_q;
      zero_d     = zero_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d    = a_in;
               b_d    = b_in;
               mode_d = mode;
               k_d    = '0;
               iter_d = '0;
               if ((a_in == '0) || (b_in == '0)) begin
                  gcd_d      = a_in | b_in;
                  zero_d     = 1'b1;
                  iter_out_d = '0;
                  state_d    = S_DONE;
               end else begin
                  zero_d  = 1'b0;
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            iter_d = iter_inc;
            if (a_q == b_q) begin
               gcd_d      = mode_q ? (a_q << k_q) : a_q;
               iter_out_d = iter_inc;
               state_d    = S_DONE;
            end else if (!mode_q) begin
               if (a_q > b_q) a_d = diff_ab;
               else           b_d = diff_ba;
            end else if (!a_q[0] && !b_q[0]) begin
               a_d = a_q >> 1;
               b_d = b_q >> 1;
               k_d = k_q + K_W'(1);
            end else if (!a_q[0]) begin
               a_d = a_q >> 1;
            end else if (!b_q[0]) begin
               b_d = b_q >> 1;
            end else if (a_q > b_q) begin
               // Both odd here, so the difference is even and the halving is exact.
               a_d = diff_ab >> 1;
            end else begin
               b_d = diff_ba >> 1;
            end
         end

         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         k_q        <= '0;
         iter_q     <= '0;
         mode_q     <= 1'b0;
         gcd_q      <= '0;
         iter_out_q <= '0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         k_q        <= k_d;
         iter_q     <= iter_d;
         mode_q     <= mode_d;
         gcd_q      <= gcd_d;
         iter_out_q <= iter_out_d;
         zero_q     <= zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign gcd_out   = gcd_q;
   assign iter_out  = iter_out_q;
   assign zero_flag = zero_q;

endmodule

// File: tb/tb_gcd_engine_param.sv
// Bench for gcd_engine_param: default 16-bit instance plus an 8-bit instance,
// expected results queued at stimulus time and popped when a result is presented.
module tb_gcd_engine_param;

   typedef struct {
      logic [15:0] g;
      logic [16:0] it;
      logic        z;
      logic        chk_it;
   } exp_t;

   typedef struct {
      logic [7:0] g;
      logic [8:0] it;
   } exp8_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, mode;
   logic [15:0] a_in, b_in;
   logic        in_ready, out_valid, zero_flag;
   logic [15:0] gcd_out;
   logic [16:0] iter_out;

   logic        in_valid8, out_ready8, mode8;
   logic [7:0]  a8, b8;
   logic        in_ready8, out_valid8, zero8;
   logic [7:0]  gcd8;
   logic [8:0]  iter8;

   int errors = 0;
   int checks = 0;
   exp_t  sb[$];
   exp8_t sb8[$];

   always #5 clk = ~clk;

   gcd_engine_param #(.WIDTH(16), .ITER_W(17)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .gcd_out(gcd_out), .iter_out(iter_out),
      .zero_flag(zero_flag)
   );

   gcd_engine_param #(.WIDTH(8), .ITER_W(9)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a_in(a8), .b_in(b8), .mode(mode8), .out_valid(out_valid8),
      .out_ready(out_ready8), .gcd_out(gcd8), .iter_out(iter8),
      .zero_flag(zero8)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Drives one job into the 16-bit instance and queues its expected result.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m, input exp_t e);
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      mode     = m;
      tick();
      in_valid = 1'b0;
      sb.push_back(e);
   endtask

   // Counts cycles after the accept edge until out_valid; -1 on timeout.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 400) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (gcd_out !== 16'd0) begin errors++; $display("FAIL reset_gcd: got %0d expected 0", gcd_out); end
      checks++; if (iter_out !== 17'd0) begin errors++; $display("FAIL reset_iter: got %0d expected 0", iter_out); end
      checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero_flag); end
      rst_n = 1'b1;
      tick();
      $display("reset: in_ready=%b out_valid=%b gcd=%0d", in_ready, out_valid, gcd_out);
   endtask

   task automatic test_mode0();
      int lat;
      exp_t e;
      send(16'd143, 16'd78, 1'b0, '{16'd13, 17'd7, 1'b0, 1'b1});
      wait_valid(lat);
      e = sb.pop_front();
      checks++; if (lat !== 7) begin errors++; $display("FAIL mode0_latency: got %0d expected 7", lat); end
      checks++; if (gcd_out !== e.g) begin errors++; $display("FAIL mode0_gcd: got %0d expected %0d", gcd_out, e.g); end
      checks++; if (iter_out !== e.it) begin errors++; $display("FAIL mode0_iter: got %0d expected %0d", iter_out, e.it); end
      checks++; if (zero_flag !== e.z) begin errors++; $display("FAIL mode0_zero: got %b expected %b", zero_flag, e.z); end
      $display("job mode0 (143,78): gcd=%0d iter=%0d lat=%0d", gcd_out, iter_out, lat);
      release_result();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mode0_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
   endtask

   task automatic test_abort();
      int seen = 0;
      send(16'd143, 16'd78, 1'b0, '{16'd13, 17'd7, 1'b0, 1'b1});
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
      checks++; if (gcd_out !== 16'd0) begin errors++; $display("FAIL abort_gcd: got %0d expected 0", gcd_out); end
      checks++; if (iter_out !== 17'd0) begin errors++; $display("FAIL abort_iter: got %0d expected 0", iter_out); end
      rst_n = 1'b1;
      sb.delete();
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); end
      $display("abort: job dropped, valid cycles afterwards=%0d", seen);
   endtask

   task automatic test_mode1();
      int lat;
      exp_t e;
      logic [15:0] av[2] = '{16'd143, 16'd48};
      logic [15:0] bv[2] = '{16'd78, 16'd18};
      logic [15:0] gv[2] = '{16'd13, 16'd6};
      for (int j = 0; j < 2; j++) begin
         send(av[j], bv[j], 1'b1, '{gv[j], 17'd6, 1'b0, 1'b1});
         wait_valid(lat);
         e = sb.pop_front();
         checks++; if (lat !== 6) begin errors++; $display("FAIL mode1_latency: got %0d expected 6", lat); end
         checks++; if (gcd_out !== e.g) begin errors++; $display("FAIL mode1_gcd: got %0d expected %0d", gcd_out, e.g); end
         checks++; if (iter_out !== e.it) begin errors++; $display("FAIL mode1_iter: got %0d expected %0d", iter_out, e.it); end
         $display("job mode1 (%0d,%0d): gcd=%0d iter=%0d", av[j], bv[j], gcd_out, iter_out);
         release_result();
      end
   endtask

   task automatic test_zero();
      int lat;
      exp_t e;
      logic [15:0] av[3] = '{16'd0, 16'd0, 16'd91};
      logic [15:0] bv[3] = '{16'd35, 16'd0, 16'd0};
      for (int j = 0; j < 3; j++) begin
         send(av[j], bv[j], j[0], '{av[j] | bv[j], 17'd0, 1'b1, 1'b1});
         wait_valid(lat);
         e = sb.pop_front();
         checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency: got %0d cycles after accept edge expected 0", lat); end
         checks++; if (gcd_out !== e.g) begin errors++; $display("FAIL zero_gcd: got %0d expected %0d", gcd_out, e.g); end
         checks++; if (zero_flag !== e.z) begin errors++; $display("FAIL zero_flag: got %b expected %b", zero_flag, e.z); end
         checks++; if (iter_out !== e.it) begin errors++; $display("FAIL zero_iter: got %0d expected %0d", iter_out, e.it); end
         $display("job zero (%0d,%0d): gcd=%0d zero_flag=%b", av[j], bv[j], gcd_out, zero_flag);
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      exp_t e;
      send(16'd60, 16'd36, 1'b0, '{16'd12, 17'd4, 1'b0, 1'b1});
      wait_valid(lat);
      checks++; if (lat < 0) begin errors++; $display("FAIL bp_timeout: got no out_valid expected result"); end
      in_valid = 1'b1;
      a_in = 16'd21;
      b_in = 16'd14;
      mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || gcd_out !== 16'd12) begin
            errors++;
            $display("FAIL bp_hold: got out_valid=%b in_ready=%b gcd=%0d expected 1/0/12", out_valid, in_ready, gcd_out);
         end
         tick();
      end
      e = sb.pop_front();
      checks++; if (gcd_out !== e.g) begin errors++; $display("FAIL bp_gcd: got %0d expected %0d", gcd_out, e.g); end
      checks++; if (iter_out !== e.it) begin errors++; $display("FAIL bp_iter: got %0d expected %0d", iter_out, e.it); end
      $display("job bp (60,36): gcd=%0d held 5 cycles", gcd_out);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
      sb.push_back('{16'd7, 17'd3, 1'b0, 1'b1});
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_pending_accept: got in_ready=%b expected 0", in_ready); end
      wait_valid(lat);
      e = sb.pop_front();
      checks++; if (gcd_out !== e.g) begin errors++; $display("FAIL bp_next_gcd: got %0d expected %0d", gcd_out, e.g); end
      checks++; if (iter_out !== e.it) begin errors++; $display("FAIL bp_next_iter: got %0d expected %0d", iter_out, e.it); end
      $display("job pending mode1 (21,14): gcd=%0d iter=%0d", gcd_out, iter_out);
      release_result();
   endtask

   task automatic test_back_to_back();
      int lat;
      exp_t e;
      logic [15:0] a, b;
      logic m;
      for (int j = 0; j < 16; j++) begin
         a = 16'($urandom_range(0, 200));
         b = 16'($urandom_range(0, 200));
         m = 1'($urandom_range(0, 1));
         send(a, b, m, '{ref_gcd(a, b), 17'd0, (a == 0 || b == 0), 1'b0});
         wait_valid(lat);
         checks++; if (lat < 0) begin errors++; $display("FAIL b2b_timeout: got no out_valid for (%0d,%0d) expected result", a, b); end
         e = sb.pop_front();
         checks++; if (gcd_out !== e.g) begin errors++; $display("FAIL b2b_gcd: (%0d,%0d) mode %0d got %0d expected %0d", a, b, m, gcd_out, e.g); end
         checks++; if (zero_flag !== e.z) begin errors++; $display("FAIL b2b_zero: got %b expected %b", zero_flag, e.z); end
         $display("job b2b (%0d,%0d) mode%0d: gcd=%0d iter=%0d", a, b, m, gcd_out, iter_out);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_width8();
      int lat;
      exp8_t e;
      logic [7:0] av[2] = '{8'd255, 8'd200};
      logic [7:0] bv[2] = '{8'd1, 8'd200};
      logic [7:0] gv[2] = '{8'd1, 8'd200};
      logic [8:0] iv[2] = '{9'd255, 9'd1};
      for (int j = 0; j < 2; j++) begin
         in_valid8 = 1'b1;
         a8 = av[j];
         b8 = bv[j];
         mode8 = j[0];
         tick();
         in_valid8 = 1'b0;
         sb8.push_back('{gv[j], iv[j]});
         lat = 0;
         while (!out_valid8 && lat < 400) begin
            tick();
            lat++;
         end
         e = sb8.pop_front();
         checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL w8_timeout: got out_valid=%b expected 1", out_valid8); end
         checks++; if (gcd8 !== e.g) begin errors++; $display("FAIL w8_gcd: got %0d expected %0d", gcd8, e.g); end
         checks++; if (iter8 !== e.it) begin errors++; $display("FAIL w8_iter: got %0d expected %0d", iter8, e.it); end
         checks++; if (lat !== int'(e.it)) begin errors++; $display("FAIL w8_latency: got %0d expected %0d", lat, e.it); end
         $display("job w8 (%0d,%0d) mode%0d: gcd=%0d iter=%0d", av[j], bv[j], j, gcd8, iter8);
         out_ready8 = 1'b1;
         tick();
         out_ready8 = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; a_in = '0; b_in = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
      tick();
      test_reset();
      test_mode0();
      test_abort();
      test_mode1();
      test_zero();
      test_backpressure();
      test_back_to_back();
      test_width8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
